ddr_cmd_scheduler: RTL and testbench

Single-rank DDR3 command scheduler sitting between the controller's read and write request queues and the DDR command bus of `ddr_interface`. Arbitrates round-robin between one read and one write requester, tracks open rows in 8 banks (open-page policy), and issues ACT/RD/WR/PRE (and optionally REF) while enforcing tRCD, tRP, tRAS and tCCD in ck_t cycles. One command is in flight at a time; the DQS/DQ timing checks downstream see only correctly spaced CAS commands from this block.

---
 rtl/ddr_cmd_scheduler.sv | 261 ++++++++++++++++++++++++++
 tb/tb_ddr_cmd_scheduler.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_cmd_scheduler.sv
// Single-rank DDR3 command scheduler: round-robin read/write arbitration, open-page bank table,
// ACT/RD/WR/PRE spacing (tRCD/tRP/tRAS/tCCD). Define DDR_REFRESH_EN to add periodic PRE-all + REF.
module ddr_cmd_scheduler #(
    parameter int TRCD  = 5,
    parameter int TRP   = 5,
    parameter int TRAS  = 15,
    parameter int TCCD  = 4,
    parameter int TRFC  = 44,
    parameter int TREFI = 3120,
    parameter int ROW_W = 14,
    parameter int COL_W = 10
) (
    input  logic             ck_t,
    input  logic             reset_n,
    input  logic             rd_valid,
    output logic             rd_ready,
    input  logic [2:0]       rd_ba,
    input  logic [ROW_W-1:0] rd_row,
    input  logic [COL_W-1:0] rd_col,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [2:0]       wr_ba,
    input  logic [ROW_W-1:0] wr_row,
    input  logic [COL_W-1:0] wr_col,
    output logic             cs_n,
    output logic             ras_n,
    output logic             cas_n,
    output logic             we_n,
    output logic [2:0]       ba,
    output logic [ROW_W-1:0] addr,
    output logic             rd_start,
    output logic             wr_start,
    output logic             busy,
    output logic [3:0]       state_dbg
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One counter width for every timing counter, wide enough for the largest interval.
    localparam int T_MAX = max2(max2(max2(TRCD, TRP), max2(TRAS, TCCD)), max2(TRFC, TREFI));
    localparam int CNT_W = $clog2(T_MAX + 1);

    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;

    localparam logic [ROW_W-1:0] A10_ADDR = ROW_W'(1) << 10;

    typedef enum logic [3:0] {
        S_IDLE, S_ACT, S_WAIT_RCD, S_CAS, S_WAIT_CCD, S_WAIT_RAS, S_PRE, S_WAIT_RP,
        S_RF_WAIT_RAS, S_RF_PRE, S_RF_WAIT_RP, S_RF_REF, S_RF_WAIT_RFC
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   wait_cnt, wait_nxt;
    logic [CNT_W-1:0]   ccd_cnt;
    logic [CNT_W-1:0]   tras_cnt [8];
    logic [7:0]         bank_open;
    logic [ROW_W-1:0]   bank_row [8];
    logic               prefer_rd;
    logic [2:0]         req_ba;
    logic [ROW_W-1:0]   req_row;
    logic [COL_W-1:0]   req_col;
    logic               req_wr;
    logic [2:0]         ba_q;
    logic [ROW_W-1:0]   addr_q;
    logic [3:0]         cmd;
    logic [2:0]         cmd_ba;
    logic [ROW_W-1:0]   cmd_addr;
    logic [2:0]         sel_ba;
    logic [ROW_W-1:0]   sel_row;
    logic [ROW_W-1:0]   col_addr;
    logic               all_ras_ok;
    logic               refresh_pending;

    // Handshake: a request transfers on a cycle where valid && ready; ready is combinational,
    // only ever high in IDLE (no refresh pending), and only to the granted side.

    assign col_addr  = ROW_W'(req_col);
    assign {cs_n, ras_n, cas_n, we_n} = cmd;
    assign ba        = cmd_ba;
    assign addr      = cmd_addr;
    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

    always_comb begin
        all_ras_ok = 1'b1;
        for (int b = 0; b < 8; b++) begin
            if (tras_cnt[b] > CNT_W'(1)) all_ras_ok = 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        wait_nxt  = (wait_cnt != '0) ? wait_cnt - CNT_W'(1) : '0;
        cmd       = CMD_NOP;
        cmd_ba    = ba_q;
        cmd_addr  = addr_q;
        rd_ready  = 1'b0;
        wr_ready  = 1'b0;
        rd_start  = 1'b0;
        wr_start  = 1'b0;
        sel_ba    = rd_ba;
        sel_row   = rd_row;
        case (state)
            S_IDLE: begin
                if (refresh_pending) begin
                    if (bank_open == '0)  state_nxt = S_RF_REF;
                    else if (all_ras_ok)  state_nxt = S_RF_PRE;
                    else                  state_nxt = S_RF_WAIT_RAS;
                end else begin
                    rd_ready = rd_valid && (!wr_valid || prefer_rd);
                    wr_ready = wr_valid && (!rd_valid || !prefer_rd);
                    if (wr_ready) begin
                        sel_ba  = wr_ba;
                        sel_row = wr_row;
                    end
                    // Counters at 1 reach 0 on the next cycle, so PRE can go out immediately.
                    if (rd_ready || wr_ready) begin
                        if (!bank_open[sel_ba])                    state_nxt = S_ACT;
                        else if (bank_row[sel_ba] == sel_row)      state_nxt = S_CAS;
                        else if (tras_cnt[sel_ba] <= CNT_W'(1))    state_nxt = S_PRE;
                        else                                       state_nxt = S_WAIT_RAS;
                    end
                end
            end
            S_ACT: begin
                cmd      = CMD_ACT;
                cmd_ba   = req_ba;
                cmd_addr = req_row;
                if (TRCD > 1) begin
                    state_nxt = S_WAIT_RCD;
                    wait_nxt  = CNT_W'(TRCD - 2);
                end else begin
                    state_nxt = S_CAS;
                end
            end
            S_WAIT_RCD: if (wait_cnt == '0) state_nxt = S_CAS;
            S_CAS: begin
                if (ccd_cnt == '0) begin
                    cmd       = req_wr ? CMD_WR : CMD_RD;
                    cmd_ba    = req_ba;
                    cmd_addr  = col_addr;
                    rd_start  = !req_wr;
                    wr_start  = req_wr;
                    state_nxt = S_WAIT_CCD;
                end
            end
            S_WAIT_CCD: state_nxt = S_IDLE;
            S_WAIT_RAS: if (tras_cnt[req_ba] <= CNT_W'(1)) state_nxt = S_PRE;
            S_PRE: begin
                cmd      = CMD_PRE;
                cmd_ba   = req_ba;
                cmd_addr = '0;
                if (TRP > 1) begin
                    state_nxt = S_WAIT_RP;
                    wait_nxt  = CNT_W'(TRP - 2);
                end else begin
                    state_nxt = S_ACT;
                end
            end
            S_WAIT_RP: if (wait_cnt == '0) state_nxt = S_ACT;
            S_RF_WAIT_RAS: if (all_ras_ok) state_nxt = S_RF_PRE;
            S_RF_PRE: begin
                cmd      = CMD_PRE;
                cmd_addr = A10_ADDR;
                if (TRP > 1) begin
                    state_nxt = S_RF_WAIT_RP;
                    wait_nxt  = CNT_W'(TRP - 2);
                end else begin
                    state_nxt = S_RF_REF;
                end
            end
            S_RF_WAIT_RP: if (wait_cnt == '0) state_nxt = S_RF_REF;
            S_RF_REF: begin
                cmd = CMD_REF;
                if (TRFC > 1) begin
                    state_nxt = S_RF_WAIT_RFC;
                    wait_nxt  = CNT_W'(TRFC - 2);
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_RF_WAIT_RFC: if (wait_cnt == '0) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge ck_t or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            ccd_cnt   <= '0;
            prefer_rd <= 1'b1;
            req_ba    <= '0;
            req_row   <= '0;
            req_col   <= '0;
            req_wr    <= 1'b0;
            ba_q      <= '0;
            addr_q    <= '0;
            bank_open <= '0;
            for (int b = 0; b < 8; b++) begin
                bank_row[b] <= '0;
                tras_cnt[b] <= '0;
            end
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            ba_q     <= cmd_ba;
            addr_q   <= cmd_addr;
            if (rd_ready) begin
                req_ba <= rd_ba; req_row <= rd_row; req_col <= rd_col; req_wr <= 1'b0;
                prefer_rd <= 1'b0;
            end else if (wr_ready) begin
                req_ba <= wr_ba; req_row <= wr_row; req_col <= wr_col; req_wr <= 1'b1;
                prefer_rd <= 1'b1;
            end
            if (cmd == CMD_RD || cmd == CMD_WR) ccd_cnt <= CNT_W'(TCCD - 1);
            else if (ccd_cnt != '0)             ccd_cnt <= ccd_cnt - CNT_W'(1);
            for (int b = 0; b < 8; b++) begin
                if (cmd == CMD_ACT && req_ba == 3'(b)) tras_cnt[b] <= CNT_W'(TRAS - 1);
                else if (tras_cnt[b] != '0)            tras_cnt[b] <= tras_cnt[b] - CNT_W'(1);
            end
            if (cmd == CMD_ACT) begin
                bank_open[req_ba] <= 1'b1;
                bank_row[req_ba]  <= req_row;
            end
            if (state == S_PRE)    bank_open[req_ba] <= 1'b0;
            if (state == S_RF_PRE) bank_open <= '0;
        end
    end

`ifdef DDR_REFRESH_EN
    logic [CNT_W-1:0] refi_cnt;
    logic             rf_done;

    assign rf_done = (state == S_RF_WAIT_RFC && wait_cnt == '0) || (state == S_RF_REF && TRFC <= 1);

    // Timer free-runs; an expiry on the same cycle as a refresh completion keeps the new one.
    always_ff @(posedge ck_t or negedge reset_n) begin
        if (!reset_n) begin
            refi_cnt        <= CNT_W'(TREFI - 1);
            refresh_pending <= 1'b0;
        end else if (refi_cnt == '0) begin
            refi_cnt        <= CNT_W'(TREFI - 1);
            refresh_pending <= 1'b1;
        end else begin
            refi_cnt <= refi_cnt - CNT_W'(1);
            if (rf_done) refresh_pending <= 1'b0;
        end
    end
`else
    assign refresh_pending = 1'b0;
`endif

endmodule

// File: tb/tb_ddr_cmd_scheduler.sv
// Directed bench for ddr_cmd_scheduler: command spacing, latency, arbitration, async reset,
// and (with DDR_REFRESH_EN) the refresh sequence.
module tb_ddr_cmd_scheduler;
    localparam int TRCD = 5, TRP = 5, TRAS = 15, TCCD = 4, TRFC = 44, TREFI = 200;
    localparam int ROW_W = 14, COL_W = 10;

    logic             ck_t, reset_n;
    logic             rd_valid, rd_ready, wr_valid, wr_ready;
    logic [2:0]       rd_ba, wr_ba, ba;
    logic [ROW_W-1:0] rd_row, wr_row, addr;
    logic [COL_W-1:0] rd_col, wr_col;
    logic             cs_n, ras_n, cas_n, we_n;
    logic             rd_start, wr_start, busy;
    logic [3:0]       state_dbg;

    ddr_cmd_scheduler #(
        .TRCD(TRCD), .TRP(TRP), .TRAS(TRAS), .TCCD(TCCD), .TRFC(TRFC), .TREFI(TREFI),
        .ROW_W(ROW_W), .COL_W(COL_W)
    ) dut (
        .ck_t(ck_t), .reset_n(reset_n),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_ba(rd_ba), .rd_row(rd_row), .rd_col(rd_col),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_ba(wr_ba), .wr_row(wr_row), .wr_col(wr_col),
        .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n), .ba(ba), .addr(addr),
        .rd_start(rd_start), .wr_start(wr_start), .busy(busy), .state_dbg(state_dbg)
    );

    // Clock / cycle counter
    initial ck_t = 1'b0;
    always #5 ck_t = ~ck_t;

    int cyc = 0;
    always @(posedge ck_t) cyc++;

    int n_checks = 0;
    int n_errors = 0;
    int bad_ready = 0;

    int act_q[$], act_addr_q[$], act_ba_q[$];
    int rd_q[$], rd_addr_q[$], wr_q[$], wr_addr_q[$];
    int pre_q[$], pre_addr_q[$], pre_ba_q[$], ref_q[$];
    int rds_q[$], wrs_q[$];
    logic [0:0] exp_q[$];
    logic [0:0] got_q[$];

    // Command monitor, sampled mid-cycle
    always @(negedge ck_t) begin
        if (reset_n) begin
            case ({cs_n, ras_n, cas_n, we_n})
                4'b0011: begin act_q.push_back(cyc); act_addr_q.push_back(int'(addr)); act_ba_q.push_back(int'(ba)); end
                4'b0101: begin rd_q.push_back(cyc); rd_addr_q.push_back(int'(addr)); end
                4'b0100: begin wr_q.push_back(cyc); wr_addr_q.push_back(int'(addr)); end
                4'b0010: begin pre_q.push_back(cyc); pre_addr_q.push_back(int'(addr)); pre_ba_q.push_back(int'(ba)); end
                4'b0001: ref_q.push_back(cyc);
                default: ;
            endcase
            if (rd_start) rds_q.push_back(cyc);
            if (wr_start) wrs_q.push_back(cyc);
            if (busy && (rd_ready || wr_ready)) bad_ready++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        act_q.delete(); act_addr_q.delete(); act_ba_q.delete();
        rd_q.delete(); rd_addr_q.delete(); wr_q.delete(); wr_addr_q.delete();
        pre_q.delete(); pre_addr_q.delete(); pre_ba_q.delete(); ref_q.delete();
        rds_q.delete(); wrs_q.delete();
    endtask

    // Driver: present one request after the next posedge, return acceptance cycle (-1 on timeout).
    task automatic send(input bit is_wr, input logic [2:0] b, input logic [ROW_W-1:0] r,
                        input logic [COL_W-1:0] c, output int acc);
        @(posedge ck_t); #1;
        acc = -1;
        if (is_wr) begin wr_ba = b; wr_row = r; wr_col = c; wr_valid = 1'b1; end
        else       begin rd_ba = b; rd_row = r; rd_col = c; rd_valid = 1'b1; end
        for (int i = 0; i < 300 && acc < 0; i++) begin
            @(negedge ck_t);
            if (is_wr ? (wr_valid && wr_ready) : (rd_valid && rd_ready)) acc = cyc;
        end
        @(posedge ck_t); #1;
        rd_valid = 1'b0;
        wr_valid = 1'b0;
        check("accept_timeout", 32'(acc >= 0), 32'd1);
    endtask

    task automatic wait_idle();
        int ok;
        ok = 0;
        for (int i = 0; i < 300 && ok == 0; i++) begin
            @(negedge ck_t);
            if (!busy) ok = 1;
        end
        check("idle_timeout", 32'(ok), 32'd1);
    endtask

    initial begin
        int a1, a2, a3, a4, a5, a6, bad;
        reset_n = 1'b0;
        rd_valid = 1'b0; wr_valid = 1'b0;
        rd_ba = '0; rd_row = '0; rd_col = '0;
        wr_ba = '0; wr_row = '0; wr_col = '0;

        // Reset values while held in reset
        #12;
        check("rst_pins", 32'({cs_n, ras_n, cas_n, we_n}), 32'h7);
        check("rst_ba", 32'(ba), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rd_ready", 32'(rd_ready), 32'd0);
        check("rst_starts", 32'({rd_start, wr_start}), 32'd0);
        repeat (3) @(posedge ck_t);
        #1 reset_n = 1'b1;

        // 100 idle cycles: nothing moves
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge ck_t);
            if ({cs_n, ras_n, cas_n, we_n} !== 4'b0111 || ba !== 3'd0 || addr !== '0 ||
                busy !== 1'b0 || rd_ready !== 1'b0 || wr_ready !== 1'b0) bad++;
        end
        check("idle_window", 32'(bad), 32'd0);
        clear_log();

        // Closed-bank read, then a row hit queued right behind it
        send(1'b0, 3'd2, 14'h0AB, 10'h010, a1);
        send(1'b0, 3'd2, 14'h0AB, 10'h020, a2);
        wait_idle();
        check("closed_act_cyc", 32'(act_q[0]), 32'(a1 + 1));
        check("closed_act_ba", 32'(act_ba_q[0]), 32'd2);
        check("closed_act_row", 32'(act_addr_q[0]), 32'h0AB);
        check("closed_rd_cyc", 32'(rd_q[0]), 32'(a1 + 6));
        check("closed_rd_addr", 32'(rd_addr_q[0]), 32'h010);
        check("closed_rd_start", 32'(rds_q[0]), 32'(a1 + 6));
        check("hit_accept_cyc", 32'(a2), 32'(a1 + 8));
        check("hit_rd_tccd", 32'(rd_q[1]), 32'(rd_q[0] + TCCD));
        check("hit_rd_addr", 32'(rd_addr_q[1]), 32'h020);
        check("hit_no_act", 32'(act_q.size()), 32'd1);

        // Row conflict before tRAS has elapsed: PRE held back to ACT+TRAS
        send(1'b1, 3'd2, 14'h0CD, 10'h033, a3);
        wait_idle();
        check("conf_pre_tras", 32'(pre_q[0]), 32'(act_q[0] + TRAS));
        check("conf_pre_ba", 32'(pre_ba_q[0]), 32'd2);
        check("conf_pre_a10", 32'(pre_addr_q[0]), 32'd0);
        check("conf_act_trp", 32'(act_q[1]), 32'(pre_q[0] + TRP));
        check("conf_act_row", 32'(act_addr_q[1]), 32'h0CD);
        check("conf_wr_trcd", 32'(wr_q[0]), 32'(act_q[1] + TRCD));
        check("conf_wr_addr", 32'(wr_addr_q[0]), 32'h033);
        check("conf_wr_start", 32'(wrs_q[0]), 32'(wr_q[0]));
        repeat (20) @(posedge ck_t);
        clear_log();

        // Conflict with tRAS long elapsed: PRE a+1, ACT a+1+TRP, WR a+1+TRP+TRCD
        send(1'b1, 3'd2, 14'h0AB, 10'h007, a4);
        wait_idle();
        check("conf2_pre", 32'(pre_q[0]), 32'(a4 + 1));
        check("conf2_act", 32'(act_q[0]), 32'(a4 + 1 + TRP));
        check("conf2_wr", 32'(wr_q[0]), 32'(a4 + 1 + TRP + TRCD));
        repeat (5) @(posedge ck_t);
        clear_log();

        // Row hit with tCCD elapsed: RD at a+1, no ACT
        send(1'b0, 3'd2, 14'h0AB, 10'h005, a5);
        wait_idle();
        check("hit2_rd", 32'(rd_q[0]), 32'(a5 + 1));
        check("hit2_no_act", 32'(act_q.size()), 32'd0);
        check("hit2_addr", 32'(rd_addr_q[0]), 32'h005);

        // Arbitration from a fresh reset: both held valid -> R,W,R,W
        @(posedge ck_t); #1 reset_n = 1'b0;
        repeat (2) @(posedge ck_t);
        #1 reset_n = 1'b1;
        clear_log();
        exp_q = '{1'b0, 1'b1, 1'b0, 1'b1};
        rd_ba = 3'd0; rd_row = 14'h001; rd_col = 10'h000;
        wr_ba = 3'd1; wr_row = 14'h002; wr_col = 10'h000;
        rd_valid = 1'b1; wr_valid = 1'b1;
        for (int i = 0; i < 300 && got_q.size() < 4; i++) begin
            @(negedge ck_t);
            if (rd_valid && rd_ready) got_q.push_back(1'b0);
            if (wr_valid && wr_ready) got_q.push_back(1'b1);
        end
        @(posedge ck_t); #1;
        rd_valid = 1'b0; wr_valid = 1'b0;
        check("arb_count", 32'(got_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) check($sformatf("arb_grant%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
        wait_idle();

        // Async reset in WAIT_RCD drops the request immediately
        send(1'b0, 3'd3, 14'h005, 10'h001, a6);
        @(posedge ck_t); #2 reset_n = 1'b0;
        #1;
        check("arst_pins", 32'({cs_n, ras_n, cas_n, we_n}), 32'h7);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_ba_addr", 32'({ba, addr}), 32'd0);
        repeat (2) @(posedge ck_t);
        #1 reset_n = 1'b1;
        clear_log();
        send(1'b0, 3'd0, 14'h001, 10'h002, a6);
        wait_idle();
        check("arst_table_cleared", 32'(act_q.size()), 32'd1);
        check("arst_act_cyc", 32'(act_q[0]), 32'(a6 + 1));
        check("bad_ready_when_busy", 32'(bad_ready), 32'd0);

`ifdef DDR_REFRESH_EN
        // Refresh with bank 1 open: PRE-all, REF tRP later, next ACT at least tRFC after REF
        @(posedge ck_t); #1 reset_n = 1'b0;
        repeat (2) @(posedge ck_t);
        #1 reset_n = 1'b1;
        clear_log();
        send(1'b0, 3'd1, 14'h009, 10'h000, a1);
        wait_idle();
        for (int i = 0; i < 600 && ref_q.size() == 0; i++) @(negedge ck_t);
        check("ref_seen", 32'(ref_q.size()), 32'd1);
        check("ref_pre_count", 32'(pre_q.size()), 32'd1);
        check("ref_pre_a10", 32'((pre_addr_q[0] >> 10) & 1), 32'd1);
        check("ref_after_trp", 32'(ref_q[0]), 32'(pre_q[0] + TRP));
        send(1'b0, 3'd1, 14'h009, 10'h000, a2);
        wait_idle();
        check("ref_act_count", 32'(act_q.size()), 32'd2);
        check("ref_trfc", 32'(act_q[1] >= ref_q[0] + TRFC), 32'd1);
`else
        repeat (300) @(posedge ck_t);
        check("no_ref", 32'(ref_q.size()), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
